ntt_mlkem_masked_gs_unmask_stage: RTL

// - Downstream of the MLKEM masked GS (INTT) butterfly; consumes its 2-share u/v outputs.
// - Tracks in-flight butterfly ops with a valid delay line, since the butterfly carries no valid.
// - Recombines shares mod q and buffers coefficient pairs in a ready/valid FIFO.
// - Issues credit-based back-pressure to the INTT controller so no butterfly result is ever lost.

---
 rtl/abr_params_pkg.sv | 20 ++
 rtl/ntt_mlkem_unmask_add_red.sv | 32 +++
 rtl/ntt_mlkem_masked_gs_unmask_stage.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/abr_params_pkg.sv
// Shared parameters for the MLKEM masked NTT datapath.
package abr_params_pkg;

    // MLKEM modulus and coefficient width
    localparam int MLKEM_Q       = 3329;
    localparam int MLKEM_COEFF_W = 12;

    // Masked butterfly pipeline depths
    localparam int MLKEM_MASKED_ADD_SUB_LATENCY = 7;
    localparam int MLKEM_MASKED_MULT_LATENCY    = 8;
    localparam int MLKEM_MASKED_GS_BF_LATENCY   = MLKEM_MASKED_ADD_SUB_LATENCY
                                                + MLKEM_MASKED_MULT_LATENCY;

    // Share width on the butterfly ports and depth of the unmask output buffer
    localparam int MLKEM_SHARE_WIDTH       = 24;
    localparam int MLKEM_UNMASK_FIFO_DEPTH = 4;

    typedef logic [MLKEM_COEFF_W-1:0] mlkem_coeff_t;

endpackage

// File: rtl/ntt_mlkem_unmask_add_red.sv
// Recombines two additive shares: s0 + s1, minus Q once if the sum reaches Q.
// Shares are expected to be residues mod Q; out-of-range shares still go through
// the same formula and the low 12 bits are returned.
module ntt_mlkem_unmask_add_red
    import abr_params_pkg::*;
#(
    parameter int WIDTH = MLKEM_SHARE_WIDTH,
    parameter int Q     = MLKEM_Q
) (
    input  logic [1:0][WIDTH-1:0] share_i,
    output mlkem_coeff_t          coeff_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] red;
    logic           unused_hi;

    // Full-width add with one extra carry bit, then a single conditional subtract
    always_comb begin
        sum = {1'b0, share_i[0]} + {1'b0, share_i[1]};
        if (sum >= (WIDTH+1)'(Q)) begin
            red = sum - (WIDTH+1)'(Q);
        end else begin
            red = sum;
        end
    end

    assign coeff_o   = red[MLKEM_COEFF_W-1:0];
    // Upper bits only matter for out-of-range shares and are dropped by design
    assign unused_hi = ^red[WIDTH:MLKEM_COEFF_W];

endmodule

// File: rtl/ntt_mlkem_masked_gs_unmask_stage.sv
// Unmask stage behind the masked GS butterfly: tracks in-flight ops with a
// valid delay line, recombines u/v shares mod Q, buffers pairs in a FIFO and
// hands credits back to the INTT controller.
//
// Handshakes:
//   issue side : an op is accepted in a clk where issue_i & issue_rdy_o. The
//                controller must not raise issue_i while issue_rdy_o is low;
//                doing so is dropped and latches err_o.
//   output side: the head transfers in a clk where out_valid_o & out_ready_i.
//                out_valid_o never drops without a transfer and u_o/v_o stay
//                stable while out_valid_o is high and out_ready_i is low.
// Credits count every op between acceptance and FIFO read, so the FIFO can
// never be written while full and no butterfly result is lost.
module ntt_mlkem_masked_gs_unmask_stage
    import abr_params_pkg::*;
#(
    parameter int WIDTH   = MLKEM_SHARE_WIDTH,
    parameter int LATENCY = MLKEM_MASKED_GS_BF_LATENCY,
    parameter int DEPTH   = MLKEM_UNMASK_FIFO_DEPTH,
    parameter int Q       = MLKEM_Q
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  zeroize,
    input  logic                  issue_i,
    output logic                  issue_rdy_o,
    input  logic [1:0][WIDTH-1:0] u_share_i,
    input  logic [1:0][WIDTH-1:0] v_share_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [11:0]           u_o,
    output logic [11:0]           v_o,
    output logic                  err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic               issue_acc;
    logic               tap;
    logic [LATENCY-1:0] dly;

    mlkem_coeff_t       u_sum;
    mlkem_coeff_t       v_sum;
    logic               comb_valid;
    mlkem_coeff_t       comb_u;
    mlkem_coeff_t       comb_v;

    mlkem_coeff_t       fifo_u [DEPTH];
    mlkem_coeff_t       fifo_v [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_cnt;
    logic               fifo_wr;
    logic               fifo_rd;
    mlkem_coeff_t       hold_u;
    mlkem_coeff_t       hold_v;

    logic [CNT_W-1:0]   credit_cnt;

    assign issue_rdy_o = (credit_cnt < CNT_W'(DEPTH));
    assign issue_acc   = issue_i & issue_rdy_o;
    assign tap         = dly[LATENCY-1];

    assign out_valid_o = (fifo_cnt != '0);
    assign fifo_wr     = comb_valid;
    assign fifo_rd     = out_valid_o & out_ready_i;

    // Head is shown straight from storage; when empty the last read pair is held
    assign u_o = out_valid_o ? fifo_u[rd_ptr] : hold_u;
    assign v_o = out_valid_o ? fifo_v[rd_ptr] : hold_v;

    ntt_mlkem_unmask_add_red #(.WIDTH(WIDTH), .Q(Q)) u_add_red (
        .share_i (u_share_i),
        .coeff_o (u_sum)
    );

    ntt_mlkem_unmask_add_red #(.WIDTH(WIDTH), .Q(Q)) v_add_red (
        .share_i (v_share_i),
        .coeff_o (v_sum)
    );

    // Valid delay line mirroring the butterfly pipeline; only accepted issues enter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dly <= '0;
        end else if (zeroize) begin
            dly <= '0;
        end else begin
            dly <= {dly[LATENCY-2:0], issue_acc};
        end
    end

    // Combine register: shares are sampled only in the clk the tap marks valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            comb_valid <= 1'b0;
            comb_u     <= '0;
            comb_v     <= '0;
        end else if (zeroize) begin
            comb_valid <= 1'b0;
            comb_u     <= '0;
            comb_v     <= '0;
        end else begin
            comb_valid <= tap;
            if (tap) begin
                comb_u <= u_sum;
                comb_v <= v_sum;
            end
        end
    end

    // FIFO storage and hold register for the last pair read out
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_u[i] <= '0;
                fifo_v[i] <= '0;
            end
            hold_u <= '0;
            hold_v <= '0;
        end else if (zeroize) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_u[i] <= '0;
                fifo_v[i] <= '0;
            end
            hold_u <= '0;
            hold_v <= '0;
        end else begin
            if (fifo_wr) begin
                fifo_u[wr_ptr] <= comb_u;
                fifo_v[wr_ptr] <= comb_v;
            end
            if (fifo_rd) begin
                hold_u <= fifo_u[rd_ptr];
                hold_v <= fifo_v[rd_ptr];
            end
        end
    end

    // FIFO pointers (wrap naturally, DEPTH is a power of 2) and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (zeroize) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (fifo_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({fifo_wr, fifo_rd})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Credit counter: ops in delay line + combine reg + FIFO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            credit_cnt <= '0;
        end else if (zeroize) begin
            credit_cnt <= '0;
        end else begin
            case ({issue_acc, fifo_rd})
                2'b10:   credit_cnt <= credit_cnt + CNT_W'(1);
                2'b01:   credit_cnt <= credit_cnt - CNT_W'(1);
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

    // Sticky error on an issue attempted without a credit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_o <= 1'b0;
        end else if (zeroize) begin
            err_o <= 1'b0;
        end else if (issue_i && !issue_rdy_o) begin
            err_o <= 1'b1;
        end
    end

endmodule
